// File: rtl/screen_dump.sv
// Streams the character RAM to the UART transmitter in row-major order,
// showing non-printable bytes as '.' and ending every row with CR LF.
module screen_dump #(
    parameter int COLS        = 50,
    parameter int ROWS        = 15,
    parameter int ADDR_W      = 12,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [7:0]        ram_rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_ready,
    input  logic              tx_busy
);
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [3:0] {
        IDLE, RD_REQ, RD_WAIT, SEND, HOLD, DRAIN, EOL_CR, EOL_LF, DONE
    } state_t;

    // Which byte of the row the current SEND/HOLD/DRAIN sequence carries.
    typedef enum logic [1:0] { PH_CELL, PH_CR, PH_LF } phase_t;

    state_t            state, state_next;
    phase_t            phase;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [HOLD_W-1:0] hold_cnt;
    logic              last_col, last_row, hold_done;
    logic [7:0]        cell_char;

    assign last_col  = (col == COL_W'(COLS - 1));
    assign last_row  = (row == ROW_W'(ROWS - 1));
    assign hold_done = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
    assign cell_char = (ram_rd_data < 8'h20 || ram_rd_data >= 8'h7F) ? 8'h2E : ram_rd_data;

    // NOTE: sequential state uses <= so every register updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output and the next state get a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE) && (state != DONE);
        done       = (state == DONE);
        ram_rd_en  = (state == RD_REQ);
        tx_ready   = (state == SEND);
        case (state)
            IDLE:    if (start) state_next = RD_REQ;
            RD_REQ:  state_next = RD_WAIT;
            RD_WAIT: state_next = SEND;
            SEND:    state_next = HOLD;
            HOLD:    if (hold_done) state_next = DRAIN;
            DRAIN: begin
                if (!tx_busy) begin
                    case (phase)
                        PH_CELL: state_next = last_col ? EOL_CR : RD_REQ;
                        PH_CR:   state_next = EOL_LF;
                        default: state_next = last_row ? DONE : RD_REQ;
                    endcase
                end
            end
            EOL_CR:  state_next = SEND;
            EOL_LF:  state_next = SEND;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase       <= PH_CELL;
            col         <= '0;
            row         <= '0;
            hold_cnt    <= '0;
            ram_rd_addr <= '0;
            tx_data     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        phase       <= PH_CELL;
                        col         <= '0;
                        row         <= '0;
                        ram_rd_addr <= '0;
                    end
                end
                RD_WAIT: tx_data  <= cell_char;
                EOL_CR:  tx_data  <= 8'h0D;
                EOL_LF:  tx_data  <= 8'h0A;
                SEND:    hold_cnt <= '0;
                HOLD:    hold_cnt <= hold_cnt + 1'b1;
                DRAIN: begin
                    if (!tx_busy) begin
                        case (phase)
                            PH_CELL: begin
                                if (last_col) begin
                                    phase <= PH_CR;
                                end else begin
                                    col         <= col + 1'b1;
                                    ram_rd_addr <= ram_rd_addr + 1'b1;
                                end
                            end
                            PH_CR: phase <= PH_LF;
                            default: begin
                                if (!last_row) begin
                                    phase       <= PH_CELL;
                                    row         <= row + 1'b1;
                                    col         <= '0;
                                    ram_rd_addr <= ram_rd_addr + 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_screen_dump.sv
// Randomized self-checking bench for screen_dump: captured UART bytes are
// compared against a screen-to-text model built from the RAM contents.
module tb_screen_dump;
    localparam int COLS    = 50;
    localparam int ROWS    = 15;
    localparam int ADDR_W  = 12;
    localparam int HOLD    = 2;
    localparam int NBYTES  = ROWS * (COLS + 2);
    localparam int MIN_GAP = 1 + HOLD + 1 + 2;
    localparam int STALL   = 5000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              tx_busy = 1'b0;
    logic              busy, done, ram_rd_en, tx_ready;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [7:0]        ram_rd_data = 8'h00;
    logic [7:0]        tx_data;

    logic       s_start = 1'b0;
    logic       s_tx_busy = 1'b0;
    logic       s_busy, s_done, s_rd_en, s_tx_ready;
    logic [3:0] s_rd_addr;
    logic [7:0] s_rd_data = 8'h00;
    logic [7:0] s_tx_data;

    screen_dump #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .tx_data(tx_data), .tx_ready(tx_ready), .tx_busy(tx_busy)
    );

    screen_dump #(.COLS(2), .ROWS(2), .ADDR_W(4), .HOLD_CYCLES(HOLD)) dut_s (
        .clk(clk), .reset(reset), .start(s_start), .busy(s_busy), .done(s_done),
        .ram_rd_en(s_rd_en), .ram_rd_addr(s_rd_addr), .ram_rd_data(s_rd_data),
        .tx_data(s_tx_data), .tx_ready(s_tx_ready), .tx_busy(s_tx_busy)
    );

    // Text RAMs with a one-cycle registered read.
    logic [7:0] ram [0:(1<<ADDR_W)-1];
    logic [7:0] s_ram [0:15];
    always @(posedge clk) if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
    always @(posedge clk) if (s_rd_en) s_rd_data <= s_ram[s_rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // UART model and byte capture for the full-size instance.
    logic [7:0] got[$];
    int         got_cyc[$];
    int         done_cnt = 0;
    int         busy_cnt = 0;
    int         busy_fix = 10;
    bit         busy_rand = 1'b0;
    int         stall_req = 0;
    int         stall_ack = 0;
    always @(negedge clk) begin
        if (tx_ready) begin
            got.push_back(tx_data);
            got_cyc.push_back(cyc);
            if (stall_req != stall_ack) begin
                busy_cnt  = STALL;
                stall_ack = stall_req;
            end else begin
                busy_cnt = busy_rand ? int'($urandom_range(0, 4)) : busy_fix;
            end
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        tx_busy = (busy_cnt != 0);
        if (done) done_cnt++;
    end

    logic [7:0] s_got[$];
    int         s_addr_q[$];
    int         s_last_tx = 0;
    int         s_done_cyc = 0;
    int         s_done_cnt = 0;
    always @(negedge clk) begin
        if (s_tx_ready) begin
            s_got.push_back(s_tx_data);
            s_last_tx = cyc;
        end
        if (s_rd_en) s_addr_q.push_back(int'(s_rd_addr));
        if (s_done) begin
            s_done_cnt++;
            s_done_cyc = cyc;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        if (obs === req) n_pass++;
        else $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, req);
    endtask

    // What a terminal capture of the screen should look like.
    function automatic logic [7:0] shown(input logic [7:0] b);
        return (b >= 8'h20 && b <= 8'h7E) ? b : 8'h2E;
    endfunction

    logic [7:0] exp_q[$];
    task automatic build_expect();
        exp_q.delete();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) exp_q.push_back(shown(ram[r * COLS + c]));
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_bytes(input string tag, input int target, input int budget);
        int k = 0;
        while (got.size() < target && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(got.size() >= target), 32'd1);
    endtask

    task automatic fill_pattern();
        for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = 8'(8'h41 + (a % 26));
    endtask

    task automatic fill_random();
        for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = 8'($urandom);
    endtask

    task automatic run_dump(input string tag, input int budget);
        int base  = got.size();
        int dbase = done_cnt;
        int k     = 0;
        build_expect();
        pulse_start();
        while (done_cnt == dbase && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt - dbase), 32'd1);
        repeat (3) tick();
        check({tag, "_done_once"}, 32'(done_cnt - dbase), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_nbytes"}, 32'(got.size() - base), 32'(NBYTES));
        for (int i = 0; i < NBYTES && base + i < got.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(got[base + i]), 32'(exp_q[i]));
    endtask

    int b, tgt, n_now, d_now, drops, k;
    logic [7:0] s_exp[$];

    initial begin
        for (int a = 0; a < 16; a++) s_ram[a] = 8'(8'h61 + a);
        fill_pattern();

        // Reset state of both instances, during and after reset.
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(ram_rd_en), 32'd0);
        check("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_s_busy", 32'(s_busy), 32'd0);
        check("idle_s_tx_ready", 32'(s_tx_ready), 32'd0);

        // Small 2x2 screen: exact stream, read addresses and done timing.
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("s_busy_rise", 32'(s_busy), 32'd1);
        k = 0;
        while (s_done_cnt == 0 && k < 500) begin
            tick();
            k++;
        end
        repeat (3) tick();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) s_exp.push_back(shown(s_ram[r * 2 + c]));
            s_exp.push_back(8'h0D);
            s_exp.push_back(8'h0A);
        end
        check("s_nbytes", 32'(s_got.size()), 32'd8);
        for (int i = 0; i < 8 && i < s_got.size(); i++)
            check($sformatf("s_byte%0d", i), 32'(s_got[i]), 32'(s_exp[i]));
        check("s_naddr", 32'(s_addr_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < s_addr_q.size(); i++)
            check($sformatf("s_addr%0d", i), 32'(s_addr_q[i]), 32'(i));
        check("s_done_once", 32'(s_done_cnt), 32'd1);
        check("s_done_timing", 32'(s_done_cyc - s_last_tx), 32'(HOLD + 2));
        check("s_busy_after", 32'(s_busy), 32'd0);

        // Letter pattern with a 10-cycle busy UART.
        busy_rand = 1'b0;
        busy_fix  = 10;
        b = got.size();
        run_dump("pattern", 20000);
        check("pattern_cr", 32'(got[b + 50]), 32'h0D);
        check("pattern_lf", 32'(got[b + 51]), 32'h0A);
        check("pattern_row1", 32'(got[b + 52]), 32'h59);

        // Non-printable filtering and back-to-back spacing with an idle UART.
        fill_random();
        ram[0] = 8'h00;
        ram[1] = 8'h7F;
        ram[2] = 8'h7E;
        ram[3] = 8'h20;
        busy_fix = 0;
        b = got.size();
        run_dump("filter", 20000);
        check("filter_b0", 32'(got[b]), 32'h2E);
        check("filter_b1", 32'(got[b + 1]), 32'h2E);
        check("filter_b2", 32'(got[b + 2]), 32'h7E);
        check("filter_b3", 32'(got[b + 3]), 32'h20);
        check("min_gap", 32'(got_cyc[b + 1] - got_cyc[b]), 32'(MIN_GAP));

        // A second start mid-dump must be ignored.
        fill_pattern();
        busy_rand = 1'b1;
        tgt = got.size() + 100;
        fork
            run_dump("restart_ignored", 20000);
            begin
                wait_bytes("restart_reach100", tgt, 20000);
                pulse_start();
            end
        join

        // Reset mid-dump aborts; a new start begins again from cell 0.
        d_now = done_cnt;
        tgt = got.size() + 300;
        pulse_start();
        wait_bytes("abort_reach300", tgt, 20000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_tx_ready", 32'(tx_ready), 32'd0);
        check("abort_rd_addr", 32'(ram_rd_addr), 32'd0);
        n_now = got.size();
        repeat (300) tick();
        check("abort_no_bytes", 32'(got.size()), 32'(n_now));
        check("abort_no_done", 32'(done_cnt), 32'(d_now));
        b = got.size();
        run_dump("abort_restart", 20000);
        check("abort_restart_first", 32'(got[b]), 32'h41);

        // UART stalls for 5000 cycles after the first byte.
        fill_random();
        stall_req++;
        tgt = got.size() + 1;
        drops = 0;
        fork
            run_dump("stall", 30000);
            begin
                wait_bytes("stall_first", tgt, 2000);
                for (int i = 0; i < 4900; i++) begin
                    tick();
                    if (!busy) drops++;
                end
                check("stall_pulses", 32'(got.size() - (tgt - 1)), 32'd1);
                check("stall_busy_drops", 32'(drops), 32'd0);
            end
        join

        // Random screens with a jittery UART.
        for (int n = 0; n < 2; n++) begin
            fill_random();
            run_dump($sformatf("random%0d", n), 20000);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
